// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/stall sequencer and its helpers.
package hazard_pkg;

  localparam int REG_W_DEFAULT = 5;
  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// destination of a load currently in EX.
module load_use_detect
  import hazard_pkg::*;
#(
  parameter int REG_W = REG_W_DEFAULT
) (
  input  logic [REG_W-1:0] if_id_rs_i,
  input  logic [REG_W-1:0] if_id_rt_i,
  input  logic             if_id_uses_rt_i,
  input  logic             id_ex_mem_read_i,
  input  logic [REG_W-1:0] id_ex_rt_i,
  output logic             load_use_o
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = (id_ex_rt_i == if_id_rs_i);
  // Rt only matters for instructions that actually read it (R-type, sw, beq).
  assign rt_hit = if_id_uses_rt_i && (id_ex_rt_i == if_id_rt_i);

  // Register 0 is hard-wired, so a load into it never creates a dependency.
  assign load_use_o = id_ex_mem_read_i
                   && (id_ex_rt_i != REG_W'(ZERO_REG))
                   && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline with a memory-wait FSM.
// Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int REG_W       = REG_W_DEFAULT,
  parameter int TIMEOUT_W   = 4,
  parameter int MEM_TIMEOUT = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] IF_ID_Rs,
  input  logic [REG_W-1:0] IF_ID_Rt,
  input  logic             IF_ID_UsesRt,
  input  logic             ID_EX_MemRead,
  input  logic [REG_W-1:0] ID_EX_Rt,
  input  logic             Branch_Taken,
  input  logic             Mem_Req,
  input  logic             Mem_Ready,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Write,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Write,
  output logic             EX_MEM_Flush,
  output logic             MEM_WB_Flush,
  output logic             Mem_Timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]      Stall_Cycles,
  output logic [31:0]      Flush_Count,
  output logic [31:0]      MemWait_Cycles
`endif
);

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_VAL = TIMEOUT_W'(MEM_TIMEOUT);

  hz_state_e            state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 timeout_q, timeout_d;
  logic                 load_use;
  logic                 mem_stall;

  load_use_detect #(
    .REG_W (REG_W)
  ) u_load_use_detect (
    .if_id_rs_i       (IF_ID_Rs),
    .if_id_rt_i       (IF_ID_Rt),
    .if_id_uses_rt_i  (IF_ID_UsesRt),
    .id_ex_mem_read_i (ID_EX_MemRead),
    .id_ex_rt_i       (ID_EX_Rt),
    .load_use_o       (load_use)
  );

  // mem_stall covers the entry cycle in RUN as well as every waiting cycle,
  // so the pipeline never advances past an unfinished access.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    mem_stall = 1'b0;

    if (state_q == RUN) begin
      if (Mem_Req && !Mem_Ready) begin
        state_d   = MEM_WAIT;
        cnt_d     = TIMEOUT_W'(1);
        mem_stall = 1'b1;
      end
    end else begin
      if (Mem_Ready) begin
        state_d = RUN;
        cnt_d   = '0;
      end else if (cnt_q == TIMEOUT_VAL) begin
        state_d   = RUN;
        cnt_d     = '0;
        timeout_d = 1'b1;
      end else begin
        cnt_d     = cnt_q + 1'b1;
        mem_stall = 1'b1;
      end
    end
  end

  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Write  = 1'b1;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Write = 1'b1;
    EX_MEM_Flush = 1'b0;
    MEM_WB_Flush = 1'b0;

    if (rst) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
    end else if (mem_stall) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      MEM_WB_Flush = 1'b1;
    end else if (Branch_Taken) begin
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
      EX_MEM_Flush = 1'b1;
    end else if (load_use) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Flush  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign Mem_Timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  logic        lu_cyc, br_cyc;
  logic [31:0] stall_q, flush_q, memwait_q;

  assign lu_cyc = !mem_stall && !Branch_Taken && load_use;
  assign br_cyc = !mem_stall && Branch_Taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q   <= '0;
      flush_q   <= '0;
      memwait_q <= '0;
    end else begin
      if (lu_cyc)    stall_q   <= sat_inc(stall_q);
      if (br_cyc)    flush_q   <= sat_inc(flush_q);
      if (mem_stall) memwait_q <= sat_inc(memwait_q);
    end
  end

  assign Stall_Cycles   = stall_q;
  assign Flush_Count    = flush_q;
  assign MemWait_Cycles = memwait_q;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller: per-cycle expectations are queued
// as stimulus is applied and compared against the combinational outputs.
module tb_hazard_stall_controller;

  localparam logic [7:0] DEF = 8'b11010100;
  localparam logic [7:0] LU  = 8'b00011100;
  localparam logic [7:0] BR  = 8'b11111110;
  localparam logic [7:0] MW  = 8'b00000001;
  localparam logic [7:0] RS  = 8'b00000000;

  typedef struct packed {
    logic       rst;
    logic       memread;
    logic [4:0] exrt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses;
    logic       br;
    logic       mreq;
    logic       mrdy;
    logic [8:0] exp;
  } row_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] IF_ID_Rs, IF_ID_Rt, ID_EX_Rt;
  logic       IF_ID_UsesRt, ID_EX_MemRead, Branch_Taken, Mem_Req, Mem_Ready;
  logic       PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush;
  logic       EX_MEM_Write, EX_MEM_Flush, MEM_WB_Flush, Mem_Timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] Stall_Cycles, Flush_Count, MemWait_Cycles;
`endif

  logic [8:0] obs;
  logic [8:0] exp_q[$];
  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  hazard_stall_controller dut (
    .clk          (clk),
    .rst          (rst),
    .IF_ID_Rs     (IF_ID_Rs),
    .IF_ID_Rt     (IF_ID_Rt),
    .IF_ID_UsesRt (IF_ID_UsesRt),
    .ID_EX_MemRead(ID_EX_MemRead),
    .ID_EX_Rt     (ID_EX_Rt),
    .Branch_Taken (Branch_Taken),
    .Mem_Req      (Mem_Req),
    .Mem_Ready    (Mem_Ready),
    .PC_Write     (PC_Write),
    .IF_ID_Write  (IF_ID_Write),
    .IF_ID_Flush  (IF_ID_Flush),
    .ID_EX_Write  (ID_EX_Write),
    .ID_EX_Flush  (ID_EX_Flush),
    .EX_MEM_Write (EX_MEM_Write),
    .EX_MEM_Flush (EX_MEM_Flush),
    .MEM_WB_Flush (MEM_WB_Flush),
    .Mem_Timeout  (Mem_Timeout)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .Stall_Cycles  (Stall_Cycles),
    .Flush_Count   (Flush_Count),
    .MemWait_Cycles(MemWait_Cycles)
`endif
  );

  assign obs = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
                EX_MEM_Write, EX_MEM_Flush, MEM_WB_Flush, Mem_Timeout};

  function automatic row_t mk(input logic r, input logic m, input logic [4:0] e,
                              input logic [4:0] s, input logic [4:0] t, input logic u,
                              input logic b, input logic q, input logic y,
                              input logic [7:0] c, input logic to);
    row_t x;
    x.rst = r; x.memread = m; x.exrt = e; x.rs = s; x.rt = t; x.uses = u;
    x.br = b; x.mreq = q; x.mrdy = y; x.exp = {c, to};
    return x;
  endfunction

  task automatic apply(input row_t r);
    rst = r.rst; ID_EX_MemRead = r.memread; ID_EX_Rt = r.exrt; IF_ID_Rs = r.rs;
    IF_ID_Rt = r.rt; IF_ID_UsesRt = r.uses; Branch_Taken = r.br;
    Mem_Req = r.mreq; Mem_Ready = r.mrdy;
    exp_q.push_back(r.exp);
  endtask

  task automatic test_reset();
    row_t rows[$];
    logic [8:0] e;
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, RS, 0));
    rows.push_back(mk(1, 1, 8, 8, 0, 0, 1, 1, 0, RS, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        failed++;
        $display("FAIL reset[%0d]: got %b, expected %b", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    row_t rows[$];
    logic [8:0] e;
    rows.push_back(mk(0, 1, 8, 8, 0, 0, 0, 0, 0, LU, 0));
    rows.push_back(mk(0, 0, 8, 8, 0, 0, 0, 0, 0, DEF, 0));
    rows.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, DEF, 0));
    rows.push_back(mk(0, 1, 8, 7, 6, 1, 0, 0, 0, DEF, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        failed++;
        $display("FAIL load_use[%0d]: got %b, expected %b", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rt_gating();
    row_t rows[$];
    logic [8:0] e;
    rows.push_back(mk(0, 1, 9, 3, 9, 0, 0, 0, 0, DEF, 0));
    rows.push_back(mk(0, 1, 9, 3, 9, 1, 0, 0, 0, LU, 0));
    rows.push_back(mk(0, 0, 9, 3, 9, 1, 0, 0, 0, DEF, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        failed++;
        $display("FAIL rt_gating[%0d]: got %b, expected %b", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    row_t rows[$];
    logic [8:0] e;
    rows.push_back(mk(0, 1, 8, 8, 0, 0, 1, 0, 0, BR, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, BR, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        failed++;
        $display("FAIL branch[%0d]: got %b, expected %b", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_wait();
    row_t rows[$];
    logic [8:0] e;
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, MW, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, MW, 0));
    rows.push_back(mk(0, 1, 8, 8, 0, 0, 0, 1, 0, MW, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, DEF, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, DEF, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        failed++;
        $display("FAIL mem_wait[%0d]: got %b, expected %b", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    row_t rows[$];
    logic [8:0] e;
    for (int k = 0; k < 12; k++) rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, MW, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, BR, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 1));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 1));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MW, 1));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, DEF, 1));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        failed++;
        $display("FAIL timeout[%0d]: got %b, expected %b", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_wait();
    row_t rows[$];
    logic [8:0] e;
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MW, 1));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, RS, 1));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0));
    for (int k = 0; k < 12; k++) rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MW, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, DEF, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 1));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, RS, 1));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        failed++;
        $display("FAIL reset_mid_wait[%0d]: got %b, expected %b", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    logic [8:0] e;
    rows.push_back(mk(0, 1, 5, 5, 0, 0, 0, 0, 0, LU, 0));
    rows.push_back(mk(0, 0, 5, 5, 0, 0, 1, 0, 0, BR, 0));
    rows.push_back(mk(0, 1, 6, 1, 6, 1, 0, 0, 0, LU, 0));
    rows.push_back(mk(0, 1, 6, 1, 6, 1, 0, 1, 0, MW, 0));
    rows.push_back(mk(0, 1, 6, 1, 6, 1, 0, 1, 1, LU, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        failed++;
        $display("FAIL back_to_back[%0d]: got %b, expected %b", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_counters();
    row_t rows[$];
    logic [8:0] e;
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, RS, 0));
    rows.push_back(mk(0, 1, 8, 8, 0, 0, 0, 0, 0, LU, 0));
    rows.push_back(mk(0, 1, 9, 9, 0, 0, 0, 0, 0, LU, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, BR, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        failed++;
        $display("FAIL perf_ctrl[%0d]: got %b, expected %b", i, obs, e);
      end
      @(posedge clk); #1;
    end
    tests++;
    if (Stall_Cycles !== 32'd2) begin
      failed++;
      $display("FAIL perf_stall: got %0d, expected 2", Stall_Cycles);
    end
    tests++;
    if (Flush_Count !== 32'd1) begin
      failed++;
      $display("FAIL perf_flush: got %0d, expected 1", Flush_Count);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ID_EX_MemRead = 1'b0; ID_EX_Rt = '0; IF_ID_Rs = '0; IF_ID_Rt = '0;
    IF_ID_UsesRt = 1'b0; Branch_Taken = 1'b0; Mem_Req = 1'b0; Mem_Ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_rt_gating();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
`ifdef HAZARD_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Watches ID/EX and EX/MEM state, the branch outcome and the data-memory handshake.
- Drives the write-enables and bubble-insert (flush) controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Sits beside the pipeline registers in the top-level datapath; contains a memory-wait FSM with a timeout counter.

Parameters:
- REG_W, 5, register-specifier width (Rs/Rt).
- TIMEOUT_W, 4, width of the memory-wait cycle counter.
- MEM_TIMEOUT, 12, max MEM_WAIT cycles before forced release; must be less than 2^TIMEOUT_W.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset
- IF_ID_Rs  in  REG_W  Rs of instruction in ID
- IF_ID_Rt  in  REG_W  Rt of instruction in ID
- IF_ID_UsesRt  in  1  ID instruction reads Rt (R-type, sw, beq)
- ID_EX_MemRead  in  1  instruction in EX is a load
- ID_EX_Rt  in  REG_W  load destination in EX
- Branch_Taken  in  1  branch resolved taken (EX/MEM Branch AND Zero)
- Mem_Req  in  1  EX/MEM holds lw/sw
- Mem_Ready  in  1  data memory completes access this cycle
- PC_Write  out  1  PC update enable
- IF_ID_Write  out  1  IF/ID enable
- IF_ID_Flush  out  1  zero IF/ID on next edge
- ID_EX_Write  out  1  ID/EX enable
- ID_EX_Flush  out  1  zero ID/EX control fields on next edge
- EX_MEM_Write  out  1  EX/MEM enable
- EX_MEM_Flush  out  1  zero EX/MEM control fields
- MEM_WB_Flush  out  1  insert bubble into MEM/WB
- Mem_Timeout  out  1  sticky: a memory wait hit MEM_TIMEOUT

Behaviour:
- Reset: clk is the single clock; rst is synchronous and active-high, sampled on posedge clk. Reset drives the state to RUN, the counter to 0 and Mem_Timeout to 0.
  - While rst is high, all *_Write outputs are 0 and all *_Flush outputs are 0.
- Outputs are combinational from the state and current inputs (zero latency). Only the state, the counter and Mem_Timeout are registered.
- Default (RUN, no hazard): all *_Write = 1, all *_Flush = 0.
- Load-use hazard in RUN, load_use = ID_EX_MemRead and ID_EX_Rt != 0 and (ID_EX_Rt == IF_ID_Rs or (IF_ID_UsesRt and ID_EX_Rt == IF_ID_Rt)):
  - PC_Write = 0, IF_ID_Write = 0, ID_EX_Flush = 1.
  - Self-clears after exactly one cycle because a bubble then occupies EX.
- Branch taken in RUN:
  - IF_ID_Flush = 1, ID_EX_Flush = 1, EX_MEM_Flush = 1, PC_Write = 1.
  - Overrides load-use; IF_ID_Write stays 1.
- Priority: memory wait > branch > load-use.
- FSM states: RUN, MEM_WAIT.
  - RUN -> MEM_WAIT when Mem_Req and not Mem_Ready; the counter loads 1.
  - In MEM_WAIT: PC_Write, IF_ID_Write, ID_EX_Write and EX_MEM_Write are 0; MEM_WB_Flush = 1; all other flushes are 0; the counter increments each cycle.
  - MEM_WAIT -> RUN when Mem_Ready. That cycle already produces RUN outputs, evaluated with branch/load-use; the counter clears.
  - MEM_WAIT -> RUN when the counter reaches MEM_TIMEOUT without Mem_Ready. Mem_Timeout is set (sticky until rst) and the access is treated as complete.
- Branch_Taken and load_use arriving during MEM_WAIT are ignored. Both sources are frozen, so they re-evaluate on the exit cycle.
- Mem_Req and Mem_Ready high in the same RUN cycle is a zero-wait access: no state change.
- rst asserted mid-MEM_WAIT returns the FSM to RUN on that edge and clears the counter and flag.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds outputs Stall_Cycles[31:0], Flush_Count[31:0] and MemWait_Cycles[31:0].
  - Stall_Cycles increments on each load-use stall cycle.
  - Flush_Count increments on each taken-branch flush cycle.
  - MemWait_Cycles increments on each MEM_WAIT cycle.
  - All counters clear on rst, saturate at all-ones and are ignored by control logic.
- Undefined: ports and counters are absent; control behaviour is identical.

Decomposition:
- Shared package hazard_pkg holds:
  - the state encoding typedef (RUN = 1'b0, MEM_WAIT = 1'b1);
  - the REG_W default;
  - the constant ZERO_REG = 5'd0.
- One natural sub-module: load_use_detect, a combinational comparator producing load_use, reusable by a future forwarding unit.

Test Plan:
- Load-use: ID_EX_MemRead=1, ID_EX_Rt=8, IF_ID_Rs=8 -> one cycle with PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1. With ID_EX_Rt=0 -> no stall.
- Rt compare gating: ID_EX_Rt=9, IF_ID_Rt=9, IF_ID_UsesRt=0 -> no stall; with IF_ID_UsesRt=1 -> stall.
- Branch vs load-use in the same cycle: Branch_Taken=1 and load_use=1 -> IF_ID_Flush=ID_EX_Flush=EX_MEM_Flush=1, PC_Write=1.
- Memory wait: Mem_Req=1, Mem_Ready low for 3 cycles -> 3 cycles of all writes=0 and MEM_WB_Flush=1. On the 4th cycle Mem_Ready=1 -> RUN outputs; Mem_Timeout=0.
- Timeout: Mem_Ready held 0 -> release after 12 MEM_WAIT cycles, Mem_Timeout=1 and stays 1 until rst. Branch_Taken=1 held throughout -> flushes fire only on the exit cycle.
- Reset mid-wait: rst=1 on the 2nd MEM_WAIT cycle -> next edge state=RUN, counter=0, outputs at reset values. With HAZARD_PERF_CNT_EN: 2 load-use stalls plus 1 branch -> Stall_Cycles=2, Flush_Count=1.
